sgd_update_seq: RTL and testbench
=================================

SGD_UPDATE_SEQ -- requirements
Module: sgd_update_seq

Interface
REQ-001 Parameters: WIDTH, 32, word width; FRAC, 24, fraction bits (Q8.24); NUM, 45, input count; NUM_LSTM, 8, cell count; CNT_W, 16, saturation-counter width.
REQ-002 Derived: ROW = NUM+NUM_LSTM+1 (weights plus bias); N = 4*NUM_LSTM*ROW entries; ADDR_W = clog2(N).
REQ-003 Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  begin a full update sweep.
- abort  in  1  terminate the sweep.
- i_lr  in  WIDTH  signed learning rate, negative for descent (default use 32'hFFE66667 = -0.1).
- i_clip_en  in  1  enable gradient clipping.
- i_clip  in  WIDTH  clip magnitude, positive.
- o_addr  out  ADDR_W  shared weight/gradient address.
- o_rd_en  out  1  read strobe.
- i_w  in  WIDTH  weight read data, valid 1 cycle after o_rd_en.
- i_grad  in  WIDTH  gradient read data, valid 1 cycle after o_rd_en.
- o_wr_en  out  1  weight write strobe.
- o_wr_data  out  WIDTH  updated weight.
- o_busy  out  1  sweep active.
- o_done  out  1  one-cycle pulse at normal completion.
- o_aborted  out  1  one-cycle pulse after abort.
- o_sat_cnt  out  CNT_W  saturation events this sweep.

Function
REQ-004 Address map: addr = (g*NUM_LSTM + j)*ROW + m; gate g order a,i,f,o; m = ROW-1 is bias.
REQ-005 FSM states: IDLE, RD, UPD, WR, DONE, ABT. All outputs are Moore-decoded or registered.
REQ-006 IDLE: start=1 -> RD; o_addr=0; o_sat_cnt cleared to 0.
REQ-007 RD: o_rd_en=1 -> UPD.
REQ-008 UPD: capture i_w and i_grad; compute the new weight -> WR.
REQ-009 WR: o_wr_en=1, o_wr_data=new weight, o_addr unchanged; if o_addr==N-1 -> DONE, else o_addr+1 -> RD.
REQ-010 DONE: o_done=1 for one cycle -> IDLE.
REQ-011 Timing: with start sampled at edge 0, entry k occupies cycles 3k+1..3k+3 and o_done is high in cycle 3N+1.
REQ-012 Clipping: when i_clip_en=1, the gradient is clamped to [-i_clip, +i_clip] before multiply; otherwise it passes unchanged.
REQ-013 Product: full 2*WIDTH signed product of i_lr and the clipped gradient, arithmetic right shift by FRAC (floor), saturated to WIDTH.
REQ-014 Update: new = w + product, saturated to [0x80..0, 0x7F..F].
REQ-015 Saturation: each saturation (product or sum) increments o_sat_cnt by 1 per entry, at most once per entry; the counter holds at its maximum.
REQ-016 Busy: o_busy=1 in RD, UPD, WR, DONE.
REQ-017 start while busy is ignored.
REQ-018 Abort: abort=1 in any busy state -> ABT at the next edge; a write in the WR cycle coinciding with abort still occurs; no o_done.
REQ-019 ABT: o_aborted=1 for one cycle -> IDLE; o_sat_cnt is retained.
REQ-020 Simultaneous start and abort in IDLE: abort wins and the FSM stays in IDLE.

Reset
REQ-021 With rst=0: state=IDLE, o_addr=0, all strobes and pulses 0, o_wr_data=0, o_sat_cnt=0, captured registers 0; this applies immediately, including mid-sweep.
REQ-022 After rst deasserts, no write occurs until a new start.

Structure
REQ-023 The shared package lstm_pkg holds the Q-format constants (WIDTH, FRAC), the gate index constants (A=0, I=1, F=2, O=3), LR_DEFAULT=32'hFFE66667, and the FSM state type.
REQ-024 Clip, multiply, shift and saturating add are isolated in the combinational sub-module sat_mac, which also outputs a sat flag; the FSM lives in sgd_update_seq.

Verification (NUM=2, NUM_LSTM=1, so N=16)
REQ-025 w=0x01000000, g=0x00800000, lr=0xFFE66667, clip off -> o_wr_data=0x00F33333, sat_cnt=0.
REQ-026 w=0x7FFFFF00, g=0xF0000000, lr=0xFFE66667 -> o_wr_data=0x7FFFFFFF, sat_cnt=1.
REQ-027 clip_en=1, clip=0x00100000, g=0x01000000, w=0, lr=0xFF000000 -> o_wr_data=0xFFF00000.
REQ-028 Full sweep -> 16 writes at addresses 0..15 ascending, each 3 cycles apart; biases at 3, 7, 11, 15; o_done in cycle 49 only; start pulsed at cycle 20 is ignored.
REQ-029 abort at cycle 9 (WR of entry 2) -> writes for entries 0..2 only, o_aborted in cycle 10, no o_done, IDLE in cycle 11.
REQ-030 rst low at cycle 14 -> all outputs zero immediately, no further writes; a subsequent start restarts at address 0.

Source files
------------

// File: rtl/lstm_pkg.sv
// Shared constants for the LSTM training blocks: Q8.24 word format, gate
// indices, default learning rate and the weight-update sequencer state type.
package lstm_pkg;
   localparam int WIDTH = 32;
   localparam int FRAC  = 24;

   localparam int GATE_A = 0;
   localparam int GATE_I = 1;
   localparam int GATE_F = 2;
   localparam int GATE_O = 3;

   localparam logic [WIDTH-1:0] LR_DEFAULT = 32'hFFE66667;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_UPD,
      S_WR,
      S_DONE,
      S_ABT
   } state_e;
endpackage

// File: rtl/sgd_update_seq_sat_mac.sv
// Combinational SGD step: optional gradient clamp, lr*grad in full precision,
// floor shift back to Q format, then saturating accumulate onto the weight.
module sat_mac
   import lstm_pkg::*;
#(
   parameter int W = WIDTH,
   parameter int F = FRAC
) (
   input  logic [W-1:0] i_w,
   input  logic [W-1:0] i_grad,
   input  logic [W-1:0] i_lr,
   input  logic         i_clip_en,
   input  logic [W-1:0] i_clip,
   output logic [W-1:0] o_w,
   output logic         o_sat
);
   localparam logic signed [W-1:0]   MAXV = {1'b0, {(W-1){1'b1}}};
   localparam logic signed [W-1:0]   MINV = {1'b1, {(W-1){1'b0}}};
   localparam logic signed [2*W-1:0] PMAX = (2*W)'(MAXV);
   localparam logic signed [2*W-1:0] PMIN = (2*W)'(MINV);

   logic signed [W-1:0]   clip_s, nclip_s, gc, p_sat;
   logic signed [2*W-1:0] lr_x, gc_x, prod, shr;
   logic signed [W:0]     sum;
   logic                  p_ovf, s_ovf;

   always_comb begin
      clip_s  = signed'(i_clip);
      nclip_s = -clip_s;
      gc      = signed'(i_grad);
      if (i_clip_en) begin
         if (gc > clip_s)       gc = clip_s;
         else if (gc < nclip_s) gc = nclip_s;
      end
      lr_x  = (2*W)'(signed'(i_lr));
      gc_x  = (2*W)'(gc);
      prod  = lr_x * gc_x;
      // >>> on a signed value rounds toward minus infinity, which is the floor we want
      shr   = prod >>> F;
      p_ovf = (shr > PMAX) || (shr < PMIN);
      p_sat = p_ovf ? (shr[2*W-1] ? MINV : MAXV) : shr[W-1:0];
      sum   = (W+1)'(signed'(i_w)) + (W+1)'(p_sat);
      s_ovf = sum[W] != sum[W-1];
      o_w   = s_ovf ? (sum[W] ? MINV : MAXV) : sum[W-1:0];
      o_sat = p_ovf | s_ovf;
   end
endmodule

// File: rtl/sgd_update_seq.sv
// Sweeps every LSTM weight/bias entry once: read, update through sat_mac,
// write back, three cycles per entry; abortable and counts saturations.
module sgd_update_seq
   import lstm_pkg::*;
#(
   parameter  int WIDTH    = lstm_pkg::WIDTH,
   parameter  int FRAC     = lstm_pkg::FRAC,
   parameter  int NUM      = 45,
   parameter  int NUM_LSTM = 8,
   parameter  int CNT_W    = 16,
   localparam int ROW      = NUM + NUM_LSTM + 1,
   localparam int N        = 4 * NUM_LSTM * ROW,
   localparam int ADDR_W   = $clog2(N)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [WIDTH-1:0]  i_lr,
   input  logic              i_clip_en,
   input  logic [WIDTH-1:0]  i_clip,
   output logic [ADDR_W-1:0] o_addr,
   output logic              o_rd_en,
   input  logic [WIDTH-1:0]  i_w,
   input  logic [WIDTH-1:0]  i_grad,
   output logic              o_wr_en,
   output logic [WIDTH-1:0]  o_wr_data,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_aborted,
   output logic [CNT_W-1:0]  o_sat_cnt
);
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 1);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [WIDTH-1:0]  wr_data_q, wr_data_d;
   logic [CNT_W-1:0]  sat_cnt_q, sat_cnt_d;
   logic [WIDTH-1:0]  mac_w;
   logic              mac_sat;

   sat_mac #(.W(WIDTH), .F(FRAC)) u_mac (
      .i_w       (i_w),
      .i_grad    (i_grad),
      .i_lr      (i_lr),
      .i_clip_en (i_clip_en),
      .i_clip    (i_clip),
      .o_w       (mac_w),
      .o_sat     (mac_sat)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         addr_q    <= '0;
         wr_data_q <= '0;
         sat_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wr_data_q <= wr_data_d;
         sat_cnt_q <= sat_cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start && !abort) state_d = S_RD;
         S_RD:    state_d = S_UPD;
         S_UPD:   state_d = S_WR;
         S_WR:    state_d = (addr_q == LAST) ? S_DONE : S_RD;
         S_DONE:  state_d = S_IDLE;
         S_ABT:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (abort && (state_q inside {S_RD, S_UPD, S_WR, S_DONE})) state_d = S_ABT;

      addr_d    = addr_q;
      wr_data_d = wr_data_q;
      sat_cnt_d = sat_cnt_q;
      if (state_q == S_IDLE && start && !abort) sat_cnt_d = '0;
      // An entry aborted before its write does not contribute a saturation
      if (state_q == S_UPD && !abort) begin
         wr_data_d = mac_w;
         if (mac_sat && sat_cnt_q != '1) sat_cnt_d = sat_cnt_q + CNT_W'(1);
      end
      if (state_q == S_WR && state_d == S_RD) addr_d = addr_q + ADDR_W'(1);
      if (state_d inside {S_IDLE, S_ABT}) addr_d = '0;
   end

   always_comb begin
      o_rd_en   = 1'b0;
      o_wr_en   = 1'b0;
      o_busy    = 1'b0;
      o_done    = 1'b0;
      o_aborted = 1'b0;
      case (state_q)
         S_RD:    begin o_rd_en = 1'b1; o_busy = 1'b1; end
         S_UPD:   o_busy = 1'b1;
         S_WR:    begin o_wr_en = 1'b1; o_busy = 1'b1; end
         S_DONE:  begin o_done = 1'b1; o_busy = 1'b1; end
         S_ABT:   o_aborted = 1'b1;
         default: ;
      endcase
   end

   assign o_addr    = addr_q;
   assign o_wr_data = wr_data_q;
   assign o_sat_cnt = sat_cnt_q;
endmodule

// File: tb/tb_sgd_update_seq.sv
// Bench for sgd_update_seq with a 16-entry configuration: weight/gradient
// memory responder, write monitor and an arithmetic reference for each update.
module tb_sgd_update_seq;
   localparam int N = 16;

   logic        clk, rst, start, abort, i_clip_en;
   logic [31:0] i_lr, i_clip, i_w, i_grad, o_wr_data;
   logic [3:0]  o_addr;
   logic        o_rd_en, o_wr_en, o_busy, o_done, o_aborted;
   logic [15:0] o_sat_cnt;

   sgd_update_seq #(.WIDTH(32), .FRAC(24), .NUM(2), .NUM_LSTM(1), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .i_lr(i_lr), .i_clip_en(i_clip_en), .i_clip(i_clip),
      .o_addr(o_addr), .o_rd_en(o_rd_en), .i_w(i_w), .i_grad(i_grad),
      .o_wr_en(o_wr_en), .o_wr_data(o_wr_data), .o_busy(o_busy),
      .o_done(o_done), .o_aborted(o_aborted), .o_sat_cnt(o_sat_cnt)
   );

   int checks = 0, errors = 0;
   int cyc = 0, base = 0, busy_n = 0;
   logic [31:0] wmem [N];
   logic [31:0] gmem [N];
   int wq_addr[$], wq_cyc[$], dq[$], aq[$];
   logic [31:0] wq_data[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Memory: data appears one cycle after the read strobe, garbage otherwise
   initial begin : responder
      logic       pend;
      logic [3:0] paddr;
      i_w = '0; i_grad = '0;
      forever begin
         @(negedge clk); pend = o_rd_en; paddr = o_addr;
         @(posedge clk); #1;
         if (pend) begin i_w = wmem[paddr]; i_grad = gmem[paddr]; end
         else begin i_w = $urandom; i_grad = $urandom; end
      end
   end

   initial begin : monitor
      forever begin
         @(negedge clk);
         if (o_wr_en) begin
            wq_addr.push_back(int'(o_addr)); wq_data.push_back(o_wr_data); wq_cyc.push_back(cyc - base);
         end
         if (o_done)    dq.push_back(cyc - base);
         if (o_aborted) aq.push_back(cyc - base);
         if (o_busy)    busy_n++;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference update from plain integer arithmetic
   function automatic logic [31:0] ref_upd(input logic [31:0] w, g, lr, input bit ce,
                                           input logic [31:0] clip, output bit sat);
      longint MAXL = 64'sd2147483647, MINL = -64'sd2147483648;
      int wi = w, gi = g, li = lr, ci = clip;
      longint gv = gi, p, q, s;
      bit s1 = 0, s2 = 0;
      if (ce) begin
         if (gv > ci) gv = ci;
         if (gv < -longint'(ci)) gv = -longint'(ci);
      end
      p = longint'(li) * gv;
      q = p / 16777216;
      if (p < 0 && (p % 16777216) != 0) q = q - 1;
      if (q > MAXL) begin q = MAXL; s1 = 1; end
      if (q < MINL) begin q = MINL; s1 = 1; end
      s = longint'(wi) + q;
      if (s > MAXL) begin s = MAXL; s2 = 1; end
      if (s < MINL) begin s = MINL; s2 = 1; end
      sat = s1 | s2;
      return s[31:0];
   endfunction

   task automatic run_sweep(input string nm, input int abort_c, input int rst_c, input int xstart_c,
                            input int ncyc, input int exp_nw, input int exp_done, input int exp_abt,
                            input int exp_busy, input int sat_entries);
      logic [31:0] rw;
      bit          s;
      int          exp_sat = 0;
      wq_addr.delete(); wq_data.delete(); wq_cyc.delete(); dq.delete(); aq.delete();
      @(negedge clk); base = cyc; busy_n = 0; start = 1'b1;
      for (int c = 1; c <= ncyc; c++) begin
         @(negedge clk);
         start = (c == xstart_c);
         abort = (c == abort_c);
         if (c == rst_c) begin
            #2 rst = 1'b0; #1;
            chk({nm, ":rst_outs"}, {o_addr, o_rd_en, o_wr_en, o_wr_data, o_busy, o_done,
                                    o_aborted, o_sat_cnt}, 64'd0);
         end
         if (c == rst_c + 2) rst = 1'b1;
      end
      start = 1'b0; abort = 1'b0;
      chk({nm, ":nwrites"}, wq_addr.size(), exp_nw);
      for (int k = 0; k < exp_nw && k < wq_addr.size(); k++) begin
         rw = ref_upd(wmem[k], gmem[k], i_lr, i_clip_en, i_clip, s);
         chk($sformatf("%s:addr%0d", nm, k), wq_addr[k], k);
         chk($sformatf("%s:data%0d", nm, k), wq_data[k], rw);
         chk($sformatf("%s:wcyc%0d", nm, k), wq_cyc[k], 3*k + 3);
      end
      for (int k = 0; k < sat_entries; k++) begin
         void'(ref_upd(wmem[k], gmem[k], i_lr, i_clip_en, i_clip, s));
         exp_sat += int'(s);
      end
      chk({nm, ":ndone"}, dq.size(), (exp_done > 0) ? 1 : 0);
      if (exp_done > 0 && dq.size() > 0) chk({nm, ":done_cyc"}, dq[0], exp_done);
      chk({nm, ":nabt"}, aq.size(), (exp_abt > 0) ? 1 : 0);
      if (exp_abt > 0 && aq.size() > 0) chk({nm, ":abt_cyc"}, aq[0], exp_abt);
      chk({nm, ":busy_cycles"}, busy_n, exp_busy);
      chk({nm, ":sat_cnt"}, o_sat_cnt, exp_sat);
   endtask

   task automatic rand_mem();
      int v;
      for (int k = 0; k < N; k++) begin
         v = $urandom; wmem[k] = v >>> $urandom_range(0, 8);
         v = $urandom; gmem[k] = v >>> $urandom_range(0, 28);
      end
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; abort = 1'b0;
      i_lr = 32'hFFE66667; i_clip_en = 1'b0; i_clip = 32'h0100_0000;
      rand_mem();
      #1;
      chk("por_outs", {o_addr, o_rd_en, o_wr_en, o_wr_data, o_busy, o_done, o_aborted, o_sat_cnt}, 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // Single-entry vectors, each cut short by an abort in the WR of entry 0
      wmem[0] = 32'h0100_0000; gmem[0] = 32'h0080_0000;
      run_sweep("vec1", 3, -1, -1, 8, 1, 0, 4, 3, 1);
      chk("vec1_lit", wq_data.size() > 0 ? wq_data[0] : 32'hx, 32'h00F3_3333);
      chk("vec1_sat", o_sat_cnt, 0);

      wmem[0] = 32'h7FFF_FF00; gmem[0] = 32'hF000_0000;
      run_sweep("vec2", 3, -1, -1, 8, 1, 0, 4, 3, 1);
      chk("vec2_lit", wq_data.size() > 0 ? wq_data[0] : 32'hx, 32'h7FFF_FFFF);
      chk("vec2_sat", o_sat_cnt, 1);

      wmem[0] = 32'h0; gmem[0] = 32'h0100_0000;
      i_lr = 32'hFF00_0000; i_clip_en = 1'b1; i_clip = 32'h0010_0000;
      run_sweep("vec3", 3, -1, -1, 8, 1, 0, 4, 3, 1);
      chk("vec3_lit", wq_data.size() > 0 ? wq_data[0] : 32'hx, 32'hFFF0_0000);

      // Full sweep, random contents, default lr, start pulse mid-sweep ignored
      rand_mem(); i_lr = 32'hFFE66667; i_clip_en = 1'b0;
      run_sweep("full", -1, -1, 20, 55, 16, 49, 0, 49, 16);

      // Random lr with clipping, aborted in WR of entry 2
      rand_mem(); i_lr = $urandom; i_clip_en = 1'b1; i_clip = $urandom_range(1, 32'h0400_0000);
      run_sweep("abort", 9, -1, -1, 15, 3, 0, 10, 9, 3);

      // Reset mid-sweep in cycle 14: writes only for entries 0..3, counter cleared
      rand_mem(); i_lr = $urandom_range(0, 32'h0200_0000); i_clip_en = 1'b0;
      run_sweep("reset", -1, 14, -1, 30, 4, 0, 0, 14, 0);

      // Restart after reset begins again at address 0
      rand_mem(); i_lr = $urandom; i_clip_en = 1'b1; i_clip = $urandom_range(1, 32'h7FFF_FFFF);
      run_sweep("restart", -1, -1, -1, 52, 16, 49, 0, 49, 16);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
